// File: rtl/mux_tree_pipe_if.sv
// -----------------------------------------------------------------------------
// mux_tree_pipe_if
// Handshake/data bundle between wide parallel sources, the pipelined mux tree
// and the narrow downstream consumer.
//   din       N_IN*W  channel i at din[i*W +: W]
//   sel       LOG2N   channel select (ignored while scan_en=1)
//   scan_en   1       select comes from the internal scan counter
//   in_valid  1       din/sel qualifier
//   in_ready  1       tree can accept this cycle
//   dout      W       selected channel data
//   dout_idx  LOG2N   channel index that produced dout
//   out_valid 1       dout/dout_idx qualifier
//   out_ready 1       consumer accepts dout
// master = source/consumer side, slave = the mux tree.
// -----------------------------------------------------------------------------
interface mux_tree_pipe_if #(
  parameter int N_IN = 16,
  parameter int W    = 8
) ();
  localparam int LOG2N = $clog2(N_IN);

  logic [N_IN*W-1:0] din;
  logic [LOG2N-1:0]  sel;
  logic              scan_en;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      dout;
  logic [LOG2N-1:0]  dout_idx;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output din, sel, scan_en, in_valid, out_ready,
    input  in_ready, dout, dout_idx, out_valid
  );

  modport slave (
    input  din, sel, scan_en, in_valid, out_ready,
    output in_ready, dout, dout_idx, out_valid
  );
endinterface

// File: rtl/mux_tree_pipe.sv
// -----------------------------------------------------------------------------
// mux_tree_pipe
// Pipelined N_IN:1 mux tree. LOG2N levels of registered 2:1 cells, one
// register after every level, valid/ready handshake with a global stall.
// Optional auto-scan sweeps the select to serialise a wide bus.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  mux_tree_pipe_if.slave (din/sel/scan_en/in_valid/in_ready,
//        dout/dout_idx/out_valid/out_ready)
// Latency LOG2N cycles, throughput 1/cycle, stalls add cycles one-for-one.
// -----------------------------------------------------------------------------

// One registered 2:1 cell of the tree.
//   en_i  stage advance, sel_i picks b_i when 1 else a_i, q_o registered.
module mux_tree_cell #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         sel_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk) begin
    if (rst)       q_o <= '0;
    else if (en_i) q_o <= sel_i ? b_i : a_i;
  end
endmodule

module mux_tree_pipe #(
  parameter int N_IN = 16,
  parameter int W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  mux_tree_pipe_if.slave bus
);
  localparam int LOG2N = $clog2(N_IN);
  // All tree nodes in one flat array: level 0 (the inputs) at [N_IN-1:0],
  // level k starts at 2*N_IN - (2*N_IN >> k); the root is the last node.
  localparam int NODES = 2*N_IN - 1;

  logic [NODES-1:0][W-1:0]   node;
  logic [LOG2N:0][LOG2N-1:0] idx_pipe;   // [0] is the live s_eff
  logic [LOG2N:0]            vld_pipe;   // [0] is the live in_valid
  logic [LOG2N:1][LOG2N-1:0] idx_q;
  logic [LOG2N:1]            vld_q;
  logic [LOG2N-1:0]          scan_cnt_q, scan_cnt_d;
  logic [LOG2N-1:0]          s_eff;
  logic                      en;
  logic                      accept;

  // Whole pipe moves together: advance unless the root holds an item the
  // consumer is refusing.
  assign en     = bus.out_ready | ~vld_pipe[LOG2N];
  assign accept = bus.in_valid & en;
  assign s_eff  = bus.scan_en ? scan_cnt_q : bus.sel;

  assign node[N_IN-1:0]        = bus.din;
  assign idx_pipe[0]           = s_eff;
  assign vld_pipe[0]           = bus.in_valid;
  assign idx_pipe[LOG2N:1]     = idx_q;
  assign vld_pipe[LOG2N:1]     = vld_q;

  // Level k halves the node count using bit k-1 of the index that travelled
  // with the item, so each item keeps the select it was accepted with.
  for (genvar k = 1; k <= LOG2N; k++) begin : g_lvl
    localparam int IOFF = 2*N_IN - ((2*N_IN) >> (k-1));
    localparam int OOFF = 2*N_IN - ((2*N_IN) >> k);
    for (genvar j = 0; j < (N_IN >> k); j++) begin : g_cell
      mux_tree_cell #(.W(W)) u_cell (
        .clk   (clk),
        .rst   (rst),
        .en_i  (en),
        .sel_i (idx_pipe[k-1][k-1]),
        .a_i   (node[IOFF + 2*j]),
        .b_i   (node[IOFF + 2*j + 1]),
        .q_o   (node[OOFF + j])
      );
    end
  end

  // Valid and index shift alongside the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      idx_q <= '0;
    end else if (en) begin
      for (int k = 1; k <= LOG2N; k++) begin
        vld_q[k] <= vld_pipe[k-1];
        idx_q[k] <= idx_pipe[k-1];
      end
    end
  end

  // Scan counter wraps naturally since N_IN is a power of two; leaving scan
  // mode always restarts the sweep at channel 0.
  always_comb begin
    scan_cnt_d = scan_cnt_q;
    if (!bus.scan_en)  scan_cnt_d = '0;
    else if (accept)   scan_cnt_d = scan_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) scan_cnt_q <= '0;
    else     scan_cnt_q <= scan_cnt_d;
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = vld_pipe[LOG2N];
  assign bus.dout_idx  = idx_pipe[LOG2N];
  assign bus.dout      = node[NODES-1];
endmodule

// File: tb/tb_mux_tree_pipe.sv
// -----------------------------------------------------------------------------
// tb_mux_tree_pipe
// Directed + randomized stimulus against a queue model: each accepted item
// carries its expected data/index and its depth in the pipe; the head is due
// at the output once it has spent LOG2N advancing cycles inside.
// -----------------------------------------------------------------------------
module tb_mux_tree_pipe;
  localparam int N_IN  = 16;
  localparam int W     = 8;
  localparam int LOG2N = 4;

  typedef struct {
    logic [W-1:0]     data;
    logic [LOG2N-1:0] idx;
    int               age;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_tree_pipe_if #(.N_IN(N_IN), .W(W)) bus ();
  mux_tree_pipe #(.N_IN(N_IN), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  item_t q[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    scan_m = 0;
  bit    live = 0;
  bit    just_rst = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model + checker: outputs sampled mid-cycle, then the upcoming edge applied.
  always @(negedge clk) begin
    bit               exp_ov, en_m;
    logic [LOG2N-1:0] s;
    item_t            it;
    if (rst) begin
      q.delete();
      scan_m   = 0;
      live     = 1;
      just_rst = 1;
    end else if (live) begin
      exp_ov = (q.size() > 0) && (q[0].age == LOG2N);
      en_m   = bus.out_ready || !exp_ov;
      if (just_rst) begin
        chk("rst_dout", bus.dout, 0);
        chk("rst_idx", bus.dout_idx, 0);
        just_rst = 0;
      end
      chk("out_valid", bus.out_valid, exp_ov);
      chk("in_ready", bus.in_ready, en_m);
      if (exp_ov) begin
        chk("dout", bus.dout, q[0].data);
        chk("dout_idx", bus.dout_idx, q[0].idx);
      end
      if (en_m) begin
        if (exp_ov) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (bus.in_valid) begin
          s       = bus.scan_en ? LOG2N'(scan_m) : bus.sel;
          it.idx  = s;
          it.data = bus.din[s*W +: W];
          it.age  = 1;
          q.push_back(it);
        end
      end
      if (!bus.scan_en)                  scan_m = 0;
      else if (bus.in_valid && en_m)     scan_m = (scan_m + 1) % N_IN;
    end
  end

  task automatic drive(input bit iv, input logic [LOG2N-1:0] s, input bit se, input bit ordy);
    bus.in_valid  = iv;
    bus.sel       = s;
    bus.scan_en   = se;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic ramp_din();
    for (int i = 0; i < N_IN; i++) bus.din[i*W +: W] = 8'h10 + 8'(i);
  endtask

  task automatic rand_din();
    bus.din = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    bus.din = '0;
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    rst = 1'b0;

    // 1: single item, sel=11
    ramp_din();
    drive(1, 4'd11, 0, 1);
    idle(6);

    // 2: back-to-back sweep of all channels
    for (int i = 0; i < N_IN; i++) drive(1, LOG2N'(i), 0, 1);
    idle(6);

    // 3: stream with a 3-cycle consumer stall once the first output shows
    drive(1, 4'd3, 0, 1);
    drive(1, 4'd5, 0, 1);
    drive(1, 4'd7, 0, 1);
    drive(1, 4'd9, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 4'd0, 0, 0);
    idle(8);

    // 4: scan 18 acceptances with din changing each cycle, wraps past 15
    for (int i = 0; i < 18; i++) begin
      rand_din();
      drive(1, 4'(i), 1, 1);
    end
    idle(6);

    // 5: scan interrupted for one cycle restarts at index 0
    for (int i = 0; i < 5; i++) begin rand_din(); drive(1, 0, 1, 1); end
    drive(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin rand_din(); drive(1, 0, 1, 1); end
    idle(6);

    // randomized traffic: mode flips, backpressure, bubbles, rare resets
    for (int i = 0; i < 400; i++) begin
      rand_din();
      rst = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 3) != 0, LOG2N'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0);
    end
    rst = 1'b0;
    idle(6);

    // 6: reset while items are in flight and the output is stalled
    ramp_din();
    drive(1, 4'd2, 0, 1);
    drive(1, 4'd4, 0, 1);
    drive(1, 4'd6, 0, 1);
    drive(0, 0, 0, 1);
    rst = 1'b1;
    drive(0, 0, 0, 0);
    rst = 1'b0;
    idle(10);

    chk("drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
